// File: rtl/eth_frame_receiver.sv
// Ethernet frame receiver: SFD lock, header capture/filter, FCS-stripped payload stream, CRC-32/length status.
// Payload byte N leaves one cycle after byte N+4 is sampled; never backpressures (one byte per cycle).
module eth_frame_receiver #(
    parameter int unsigned MIN_PAYLOAD = 46,
    parameter int unsigned MAX_PAYLOAD = 1500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic [47:0] my_mac,
    input  logic        promisc,
    output logic [47:0] dst_mac,
    output logic [47:0] src_mac,
    output logic [15:0] ethertype,
    output logic        hdr_valid,
    output logic [7:0]  pl_data,
    output logic        pl_valid,
    output logic [15:0] pl_count,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        crc_err,
    output logic        len_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_HDR,
        S_PAYLOAD,
        S_DROP
    } state_t;

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    // Reflected CRC-32, data bit 0 first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 32'hEDB8_8320;
            else             c = c >> 1;
        end
        return c;
    endfunction

    state_t        state_q, state_d;
    logic [111:0]  hdr_q, hdr_d;
    logic [3:0]    hdr_cnt_q, hdr_cnt_d;
    logic [31:0]   crc_q, crc_d;
    logic [31:0]   dl_q, dl_d;
    logic [2:0]    dl_cnt_q, dl_cnt_d;
    logic [15:0]   fwd_cnt_q, fwd_cnt_d;
    logic [7:0]    pl_data_q, pl_data_d;
    logic          pl_valid_q, pl_valid_d;
    logic          hdr_valid_q, hdr_valid_d;
    logic          frame_done_q, frame_done_d;
    logic          frame_ok_q, frame_ok_d;
    logic          crc_err_q, crc_err_d;
    logic          len_err_q, len_err_d;
    logic [15:0]   pl_count_q, pl_count_d;

    logic [111:0]  hdr_shift;
    logic [47:0]   dst_next;
    logic          addr_match;
    logic [31:0]   crc_next;
    logic [15:0]   fwd_inc;
    logic          crc_bad;
    logic          len_bad;

    always_comb begin
        state_d      = state_q;
        hdr_d        = hdr_q;
        hdr_cnt_d    = hdr_cnt_q;
        crc_d        = crc_q;
        dl_d         = dl_q;
        dl_cnt_d     = dl_cnt_q;
        fwd_cnt_d    = fwd_cnt_q;
        pl_data_d    = pl_data_q;
        pl_valid_d   = 1'b0;
        hdr_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        frame_ok_d   = frame_ok_q;
        crc_err_d    = crc_err_q;
        len_err_d    = len_err_q;
        pl_count_d   = pl_count_q;

        hdr_shift  = {hdr_q[103:0], rx_data};
        dst_next   = hdr_shift[111:64];
        addr_match = promisc || (dst_next == my_mac) || (dst_next == 48'hFFFF_FFFF_FFFF);
        crc_next   = crc32_byte(crc_q, rx_data);
        fwd_inc    = (fwd_cnt_q == 16'hFFFF) ? fwd_cnt_q : fwd_cnt_q + 16'd1;
        crc_bad    = (crc_q != CRC_RESIDUE);
        // Under four bytes after the header means the FCS itself is missing.
        len_bad    = (dl_cnt_q != 3'd4) ||
                     (32'(fwd_cnt_q) < MIN_PAYLOAD) ||
                     (32'(fwd_cnt_q) > MAX_PAYLOAD);

        case (state_q)
            S_IDLE: begin
                if (rx_valid) state_d = (rx_data == 8'h55) ? S_PRE : S_DROP;
            end

            S_PRE: begin
                if (!rx_valid) begin
                    state_d = S_IDLE;
                end else if (rx_data == 8'hD5) begin
                    state_d   = S_HDR;
                    hdr_cnt_d = 4'd0;
                    crc_d     = CRC_INIT;
                    dl_d      = 32'd0;
                    dl_cnt_d  = 3'd0;
                    fwd_cnt_d = 16'd0;
                end else if (rx_data != 8'h55) begin
                    state_d = S_DROP;
                end
            end

            S_HDR: begin
                if (rx_valid) begin
                    hdr_d     = hdr_shift;
                    crc_d     = crc_next;
                    hdr_cnt_d = hdr_cnt_q + 4'd1;
                    if (hdr_cnt_q == 4'd13) begin
                        if (addr_match) begin
                            hdr_valid_d = 1'b1;
                            state_d     = S_PAYLOAD;
                        end else begin
                            state_d = S_DROP;
                        end
                    end
                end else begin
                    frame_done_d = 1'b1;
                    frame_ok_d   = 1'b0;
                    crc_err_d    = 1'b1;
                    len_err_d    = 1'b1;
                    pl_count_d   = 16'd0;
                    state_d      = S_IDLE;
                end
            end

            S_PAYLOAD: begin
                if (rx_valid) begin
                    crc_d = crc_next;
                    dl_d  = {dl_q[23:0], rx_data};
                    if (dl_cnt_q == 3'd4) begin
                        pl_data_d  = dl_q[31:24];
                        pl_valid_d = (32'(fwd_cnt_q) < MAX_PAYLOAD);
                        fwd_cnt_d  = fwd_inc;
                    end else begin
                        dl_cnt_d = dl_cnt_q + 3'd1;
                    end
                end else begin
                    frame_done_d = 1'b1;
                    pl_count_d   = fwd_cnt_q;
                    crc_err_d    = crc_bad;
                    len_err_d    = len_bad;
                    frame_ok_d   = !crc_bad && !len_bad;
                    state_d      = S_IDLE;
                end
            end

            S_DROP: begin
                if (!rx_valid) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            hdr_q        <= '0;
            hdr_cnt_q    <= '0;
            crc_q        <= CRC_INIT;
            dl_q         <= '0;
            dl_cnt_q     <= '0;
            fwd_cnt_q    <= '0;
            pl_data_q    <= '0;
            pl_valid_q   <= 1'b0;
            hdr_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            crc_err_q    <= 1'b0;
            len_err_q    <= 1'b0;
            pl_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            hdr_q        <= hdr_d;
            hdr_cnt_q    <= hdr_cnt_d;
            crc_q        <= crc_d;
            dl_q         <= dl_d;
            dl_cnt_q     <= dl_cnt_d;
            fwd_cnt_q    <= fwd_cnt_d;
            pl_data_q    <= pl_data_d;
            pl_valid_q   <= pl_valid_d;
            hdr_valid_q  <= hdr_valid_d;
            frame_done_q <= frame_done_d;
            frame_ok_q   <= frame_ok_d;
            crc_err_q    <= crc_err_d;
            len_err_q    <= len_err_d;
            pl_count_q   <= pl_count_d;
        end
    end

    assign dst_mac    = hdr_q[111:64];
    assign src_mac    = hdr_q[63:16];
    assign ethertype  = hdr_q[15:0];
    assign hdr_valid  = hdr_valid_q;
    assign pl_data    = pl_data_q;
    assign pl_valid   = pl_valid_q;
    assign pl_count   = pl_count_q;
    assign frame_done = frame_done_q;
    assign frame_ok   = frame_ok_q;
    assign crc_err    = crc_err_q;
    assign len_err    = len_err_q;

endmodule

// File: tb/tb_eth_frame_receiver.sv
// Directed bench for eth_frame_receiver: builds frames with FCS, watches outputs on the falling edge.
module tb_eth_frame_receiver;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [47:0] my_mac;
    logic        promisc;
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
    logic        hdr_valid;
    logic [7:0]  pl_data;
    logic        pl_valid;
    logic [15:0] pl_count;
    logic        frame_done;
    logic        frame_ok;
    logic        crc_err;
    logic        len_err;

    always #5 clk = ~clk;

    eth_frame_receiver dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .my_mac     (my_mac),
        .promisc    (promisc),
        .dst_mac    (dst_mac),
        .src_mac    (src_mac),
        .ethertype  (ethertype),
        .hdr_valid  (hdr_valid),
        .pl_data    (pl_data),
        .pl_valid   (pl_valid),
        .pl_count   (pl_count),
        .frame_done (frame_done),
        .frame_ok   (frame_ok),
        .crc_err    (crc_err),
        .len_err    (len_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Output monitor
    int          hdr_seen = 0;
    int          fd_seen  = 0;
    int          pl_n     = 0;
    logic [7:0]  pl_log [0:4095];
    logic [47:0] cap_dst, cap_src;
    logic [15:0] cap_type, cap_cnt;
    logic        cap_ok, cap_crc, cap_len;

    always @(negedge clk) begin
        if (pl_valid && pl_n < 4096) begin
            pl_log[pl_n] = pl_data;
            pl_n++;
        end
        if (hdr_valid) begin
            hdr_seen++;
            cap_dst  = dst_mac;
            cap_src  = src_mac;
            cap_type = ethertype;
        end
        if (frame_done) begin
            fd_seen++;
            cap_ok  = frame_ok;
            cap_crc = crc_err;
            cap_len = len_err;
            cap_cnt = pl_count;
        end
    end

    // Frame construction
    logic [7:0] frm [0:1599];
    int         frm_len;
    int         s_hdr, s_fd, s_pl;

    function automatic logic [31:0] crc_upd(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 32'hEDB8_8320;
            else             c = c >> 1;
        end
        return c;
    endfunction

    task automatic build_frame(input logic [47:0] dst, input logic [47:0] src,
                               input logic [15:0] typ, input int plen, input int flip_idx);
        logic [31:0] crc;
        for (int b = 0; b < 6; b++) begin
            frm[b]     = 8'(dst >> (8 * (5 - b)));
            frm[6 + b] = 8'(src >> (8 * (5 - b)));
        end
        frm[12] = typ[15:8];
        frm[13] = typ[7:0];
        for (int i = 0; i < plen; i++) frm[14 + i] = 8'(i);
        crc = 32'hFFFF_FFFF;
        for (int i = 0; i < 14 + plen; i++) crc = crc_upd(crc, frm[i]);
        crc = ~crc;
        for (int j = 0; j < 4; j++) frm[14 + plen + j] = 8'(crc >> (8 * j));
        frm_len = 18 + plen;
        if (flip_idx >= 0) frm[14 + flip_idx] = 8'hFF;
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        @(negedge clk);
        rx_valid = v;
        rx_data  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00);
    endtask

    task automatic snap();
        s_hdr = hdr_seen;
        s_fd  = fd_seen;
        s_pl  = pl_n;
    endtask

    task automatic send_frame(input int nbytes);
        snap();
        repeat (7) drive(1'b1, 8'h55);
        drive(1'b1, 8'hD5);
        for (int i = 0; i < nbytes; i++) drive(1'b1, frm[i]);
        idle(8);
    endtask

    task automatic expect_counts(input string tag, input int n_hdr, input int n_pl, input int n_fd);
        check({tag, ".hdr_pulses"}, 64'(hdr_seen - s_hdr), 64'(n_hdr));
        check({tag, ".pl_beats"},   64'(pl_n - s_pl),      64'(n_pl));
        check({tag, ".frame_done"}, 64'(fd_seen - s_fd),   64'(n_fd));
    endtask

    task automatic expect_status(input string tag, input logic ok, input logic ce,
                                 input logic le, input logic [15:0] cnt);
        check({tag, ".frame_ok"}, 64'(cap_ok),  64'(ok));
        check({tag, ".crc_err"},  64'(cap_crc), 64'(ce));
        check({tag, ".len_err"},  64'(cap_len), 64'(le));
        check({tag, ".pl_count"}, 64'(cap_cnt), 64'(cnt));
    endtask

    task automatic expect_payload(input string tag, input int plen, input int flip_idx);
        int bad;
        bad = 0;
        for (int i = 0; i < plen; i++) begin
            if (pl_log[s_pl + i] !== ((i == flip_idx) ? 8'hFF : 8'(i))) bad++;
        end
        check({tag, ".payload_bad_bytes"}, 64'(bad), 64'd0);
    endtask

    localparam logic [47:0] MAC_ME    = 48'h0200_0000_0001;
    localparam logic [47:0] MAC_SRC   = 48'h0200_0000_0002;
    localparam logic [47:0] MAC_OTHER = 48'h0200_0000_0009;
    localparam logic [47:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        my_mac   = MAC_ME;
        promisc  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.pl_valid",   64'(pl_valid),   64'd0);
        check("reset.frame_done", 64'(frame_done), 64'd0);
        check("reset.dst_mac",    64'(dst_mac),    64'd0);
        check("reset.pl_count",   64'(pl_count),   64'd0);
        rst = 1'b0;
        idle(2);

        // 1: good minimum-size frame
        build_frame(MAC_ME, MAC_SRC, 16'h0800, 46, -1);
        send_frame(frm_len);
        expect_counts("good", 1, 46, 1);
        check("good.dst_mac",   64'(cap_dst),  64'(MAC_ME));
        check("good.src_mac",   64'(cap_src),  64'(MAC_SRC));
        check("good.ethertype", 64'(cap_type), 64'h0800);
        expect_payload("good", 46, -1);
        expect_status("good", 1'b1, 1'b0, 1'b0, 16'd46);

        // 2: corrupted payload byte, FCS computed over the original
        build_frame(MAC_ME, MAC_SRC, 16'h0800, 46, 10);
        send_frame(frm_len);
        expect_counts("crcbad", 1, 46, 1);
        expect_payload("crcbad", 46, 10);
        expect_status("crcbad", 1'b0, 1'b1, 1'b0, 16'd46);

        // 3: address filter
        build_frame(MAC_OTHER, MAC_SRC, 16'h0800, 46, -1);
        send_frame(frm_len);
        expect_counts("filtered", 0, 0, 0);

        build_frame(MAC_BCAST, MAC_SRC, 16'h0806, 46, -1);
        send_frame(frm_len);
        expect_counts("bcast", 1, 46, 1);
        check("bcast.dst_mac",   64'(cap_dst),  64'(MAC_BCAST));
        check("bcast.ethertype", 64'(cap_type), 64'h0806);
        expect_status("bcast", 1'b1, 1'b0, 1'b0, 16'd46);

        promisc = 1'b1;
        build_frame(MAC_OTHER, MAC_SRC, 16'h0800, 46, -1);
        send_frame(frm_len);
        expect_counts("promisc", 1, 46, 1);
        check("promisc.dst_mac", 64'(cap_dst), 64'(MAC_OTHER));
        expect_status("promisc", 1'b1, 1'b0, 1'b0, 16'd46);
        promisc = 1'b0;

        // 4: runt frame with valid FCS, then header truncated after 9 bytes
        build_frame(MAC_ME, MAC_SRC, 16'h0800, 20, -1);
        send_frame(frm_len);
        expect_counts("runt", 1, 20, 1);
        expect_payload("runt", 20, -1);
        expect_status("runt", 1'b0, 1'b0, 1'b1, 16'd20);

        build_frame(MAC_ME, MAC_SRC, 16'h0800, 46, -1);
        send_frame(9);
        expect_counts("hdr_trunc", 0, 0, 1);
        expect_status("hdr_trunc", 1'b0, 1'b1, 1'b1, 16'd0);

        // 5: corrupted preamble, SFD hidden inside the dropped frame
        snap();
        drive(1'b1, 8'h55);
        drive(1'b1, 8'h55);
        drive(1'b1, 8'hAA);
        drive(1'b1, 8'h55);
        drive(1'b1, 8'hD5);
        for (int i = 0; i < 20; i++) drive(1'b1, frm[i]);
        idle(8);
        expect_counts("bad_pre", 0, 0, 0);

        build_frame(MAC_ME, MAC_SRC, 16'h0800, 46, -1);
        send_frame(frm_len);
        expect_counts("after_drop", 1, 46, 1);
        expect_status("after_drop", 1'b1, 1'b0, 1'b0, 16'd46);

        // 6: reset mid-payload
        snap();
        repeat (7) drive(1'b1, 8'h55);
        drive(1'b1, 8'hD5);
        for (int i = 0; i < 14 + 20; i++) drive(1'b1, frm[i]);
        @(negedge clk);
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #2;
        check("midrst.pl_valid",  64'(pl_valid),  64'd0);
        check("midrst.pl_data",   64'(pl_data),   64'd0);
        check("midrst.dst_mac",   64'(dst_mac),   64'd0);
        check("midrst.src_mac",   64'(src_mac),   64'd0);
        check("midrst.ethertype", 64'(ethertype), 64'd0);
        check("midrst.frame_ok",  64'(frame_ok),  64'd0);
        check("midrst.pl_count",  64'(pl_count),  64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(8);
        check("midrst.frame_done", 64'(fd_seen - s_fd), 64'd0);

        send_frame(frm_len);
        expect_counts("post_rst", 1, 46, 1);
        expect_payload("post_rst", 46, -1);
        expect_status("post_rst", 1'b1, 1'b0, 1'b0, 16'd46);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/eth_frame_receiver.md
Name: eth_frame_receiver

Overview:
Receive-side counterpart to the master transmitter. It consumes the byte stream that the transmitter produces (preamble, SFD, header, payload, FCS, each byte qualified by a valid strobe). It locks onto the SFD, captures and filters the 14-byte header, and streams the payload out with the 4 FCS bytes stripped. It checks the standard Ethernet CRC-32 and byte counts, then reports a per-frame status pulse.

Parameters:
MIN_PAYLOAD, 46, minimum legal payload bytes; set to 0 to accept short frames.
MAX_PAYLOAD, 1500, maximum payload bytes forwarded; bytes beyond this are suppressed and the frame is flagged.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
rx_data  in  8  received byte
rx_valid  in  1  rx_data valid; a low sample marks the end of the frame
my_mac  in  48  station address, byte 0 in [47:40]
promisc  in  1  1 = accept any destination
dst_mac  out  48  captured destination MAC, first byte in [47:40]
src_mac  out  48  captured source MAC
ethertype  out  16  captured EtherType/Length, first byte in [15:8]
hdr_valid  out  1  1-cycle pulse: header accepted by the address filter
pl_data  out  8  payload byte
pl_valid  out  1  pl_data valid
pl_count  out  16  payload bytes in the frame, excluding FCS; valid with frame_done
frame_done  out  1  1-cycle end-of-frame status pulse
frame_ok  out  1  valid with frame_done: no CRC error and no length error
crc_err  out  1  valid with frame_done
len_err  out  1  valid with frame_done

Behaviour:
- Reset: all outputs 0, state IDLE, CRC register 32'hFFFFFFFF, delay line empty. Reset mid-frame discards the frame with no frame_done; after reset the next frame is hunted from IDLE.
- All outputs are registered. The block never applies backpressure: one byte per cycle whenever rx_valid is high.
- FSM IDLE:
  - rx_valid && rx_data==8'h55 -> PRE.
  - rx_valid with any other byte -> DROP.
- FSM PRE:
  - 8'h55 stays in PRE.
  - 8'hD5 -> HDR, byte counter cleared, CRC register preset to FFFFFFFF.
  - Any other byte -> DROP.
  - rx_valid low -> IDLE silently.
- FSM HDR: the 14 bytes shift MSB-first into dst_mac, src_mac, ethertype. Every byte updates the CRC.
  - On the 14th byte, the address matches if dst==my_mac, or dst==48'hFFFFFFFFFFFF, or promisc.
  - Match: hdr_valid pulses the next cycle together with final dst_mac/src_mac/ethertype; go to PAYLOAD.
  - No match: go to DROP with no pulse.
  - rx_valid low during HDR: frame_done=1, len_err=1, crc_err=1, frame_ok=0, pl_count=0; go to IDLE.
- FSM PAYLOAD: every byte updates the CRC and enters a 4-deep delay line.
  - Once 4 bytes are held, each new byte pushes the oldest out as pl_data with pl_valid=1.
  - Latency: payload byte N appears on pl_data the cycle after byte N+4 is sampled.
  - Forwarded bytes are counted, saturating at 16'hFFFF. pl_valid is suppressed once MAX_PAYLOAD bytes have been forwarded; counting continues.
  - The 4 bytes left in the delay line at the end are the FCS and are never output.
- End of frame in PAYLOAD: the first cycle with rx_valid low.
  - On the next cycle frame_done=1 and pl_count is loaded.
  - crc_err = (CRC register != 32'hDEBB20E3), the residue after the FCS.
  - len_err = (pl_count < MIN_PAYLOAD) || (pl_count > MAX_PAYLOAD). Fewer than 4 bytes after the header also means len_err=1.
  - frame_ok = !crc_err && !len_err.
  - Go to IDLE; a 55 on the cycle after the low sample starts a new frame.
- FSM DROP: ignore bytes until rx_valid is low, then go to IDLE. No outputs are generated.
- CRC-32: IEEE 802.3 polynomial 0x04C11DB7, reflected, one byte per cycle, LSB of the byte first, init FFFFFFFF. Covers destination MAC through FCS inclusive.
- The delay line, counter and CRC are cleared at every SFD.

Test Plan:
1. Good frame: my_mac=02:00:00:00:00:01, dst=my_mac, src=02:00:00:00:00:02, type 0x0800, payload 46 bytes 0x00..0x2D, correct FCS -> hdr_valid with those values; 46 pl_valid beats carrying 0x00..0x2D, no FCS bytes; frame_done with frame_ok=1, pl_count=46.
2. Same frame with payload byte 10 flipped to 0xFF -> all 46 bytes forwarded; crc_err=1, frame_ok=0.
3. dst=02:00:00:00:00:09, promisc=0 -> no hdr_valid, no pl_valid, no frame_done. Repeat with dst=FF:FF:FF:FF:FF:FF -> accepted; repeat with promisc=1 and dst=02:00:00:00:00:09 -> accepted.
4. 20-byte payload with valid FCS, MIN_PAYLOAD=46 -> pl_count=20, len_err=1, crc_err=0. Also: rx_valid drops after 9 header bytes -> frame_done with len_err=1, pl_count=0.
5. Preamble corruption: 55 55 AA ... -> DROP, no outputs. A following good frame, started after a low gap, is received with frame_ok=1.
6. rst pulsed during payload byte 20 -> all outputs 0, no frame_done. The next good frame is received correctly.
